// File: rtl/uart_rx_fifo_if.sv
// Bus-side bundle of the UART receive FIFO: receiver write strobe, reader pop
// strobe and the status the reader observes.
interface uart_rx_fifo_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              wr_tick;
    logic [DATA_W-1:0] wr_data;
    logic              rd;
    logic              clr_ovr;
    logic [DATA_W-1:0] rd_data;
    logic              empty;
    logic              full;
    logic              almost_full;
    logic [ADDR_W:0]   count;
    logic              overrun;

    modport master (
        output wr_tick, wr_data, rd, clr_ovr,
        input  rd_data, empty, full, almost_full, count, overrun
    );

    modport slave (
        input  wr_tick, wr_data, rd, clr_ovr,
        output rd_data, empty, full, almost_full, count, overrun
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Circular first-word-fall-through receive buffer behind the UART receiver,
// with occupancy, almost-full and a sticky overrun flag for dropped bytes.
module uart_rx_fifo #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4,
    parameter int AF_LEVEL = 12
) (
    input logic           clk,
    input logic           reset,
    uart_rx_fifo_if.slave bus
);
    localparam int              DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_CNT   = (ADDR_W+1)'(AF_LEVEL);
    localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wrPtr_q, wrPtr_d;
    logic [ADDR_W-1:0] rdPtr_q, rdPtr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overrun_q, overrun_d;

    logic isEmpty, isFull, doWrite, doRead, ovrEvent;

    assign isEmpty  = (count_q == '0);
    assign isFull   = (count_q == FULL_CNT);
    // A full FIFO still accepts a write when a pop frees a slot in the same cycle.
    assign doRead   = bus.rd && !isEmpty;
    assign doWrite  = bus.wr_tick && (!isFull || bus.rd);
    assign ovrEvent = bus.wr_tick && isFull && !bus.rd;

    always_comb begin
        wrPtr_d   = doWrite ? wrPtr_q + PTR_ONE : wrPtr_q;
        rdPtr_d   = doRead  ? rdPtr_q + PTR_ONE : rdPtr_q;
        count_d   = count_q;
        case ({doWrite, doRead})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        overrun_d = overrun_q;
        if (ovrEvent) begin
            overrun_d = 1'b1;
        end else if (bus.clr_ovr) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wrPtr_q   <= wrPtr_d;
            rdPtr_q   <= rdPtr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    // Storage is deliberately left unreset; rd_data gating hides stale contents.
    always_ff @(posedge clk) begin
        if (doWrite) begin
            mem[wrPtr_q] <= bus.wr_data;
        end
    end

    assign bus.rd_data     = isEmpty ? '0 : mem[rdPtr_q];
    assign bus.empty       = isEmpty;
    assign bus.full        = isFull;
    assign bus.almost_full = (count_q >= AF_CNT);
    assign bus.count       = count_q;
    assign bus.overrun     = overrun_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed vector table, corner-case
// sequences and randomized traffic against a queue-based reference model.
module tb_uart_rx_fifo;
    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 4;
    localparam int AF_LEVEL = 12;
    localparam int DEPTH    = 16;

    typedef struct {
        logic       wr;
        logic [7:0] data;
        logic       rd;
        logic       clr;
        int         expCount;
        logic [7:0] expRdData;
        logic       expOvr;
        logic       expAf;
        logic       expFull;
        logic       expEmpty;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   testsRun    = 0;
    int   testsFailed = 0;

    logic [7:0] modelQ[$];
    logic       modelOvr;
    vec_t       vecs[10];

    always #5 clk = ~clk;

    uart_rx_fifo_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    uart_rx_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .AF_LEVEL(AF_LEVEL)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected outputs come straight from the queue contents and sticky flag.
    task automatic checkOutput(input string tag);
        int n;
        n = modelQ.size();
        checkVal({tag, " count"},   32'(bus.count),       32'(n));
        checkVal({tag, " empty"},   32'(bus.empty),       32'(n == 0));
        checkVal({tag, " full"},    32'(bus.full),        32'(n == DEPTH));
        checkVal({tag, " afull"},   32'(bus.almost_full), 32'(n >= AF_LEVEL));
        checkVal({tag, " overrun"}, 32'(bus.overrun),     32'(modelOvr));
        checkVal({tag, " rd_data"}, 32'(bus.rd_data),     (n == 0) ? 32'h0 : 32'(modelQ[0]));
    endtask

    task automatic applyStimulus(input logic wr, input logic [7:0] d, input logic rdS, input logic clr);
        int n;
        bit wasFull, rdOk, wrOk;
        bus.wr_tick = wr;
        bus.wr_data = d;
        bus.rd      = rdS;
        bus.clr_ovr = clr;
        n       = modelQ.size();
        wasFull = (n == DEPTH);
        rdOk    = rdS && (n != 0);
        wrOk    = wr && (!wasFull || rdS);
        if (rdOk) void'(modelQ.pop_front());
        if (wrOk) modelQ.push_back(d);
        if (wr && wasFull && !rdS) modelOvr = 1'b1;
        else if (clr) modelOvr = 1'b0;
        @(posedge clk);
        #1;
        bus.wr_tick = 1'b0;
        bus.wr_data = '0;
        bus.rd      = 1'b0;
        bus.clr_ovr = 1'b0;
    endtask

    initial begin
        int rdProb;
        // wr, data, rd, clr | count, rd_data, ovr, af, full, empty
        vecs[0] = '{1'b0, 8'h00, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 8'h3C, 1'b1, 1'b0, 1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 8'h11, 1'b0, 1'b0, 2, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 8'h22, 1'b1, 1'b0, 2, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 8'h00, 1'b0, 1'b1, 1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};

        reset       = 1'b1;
        bus.wr_tick = 1'b0;
        bus.wr_data = '0;
        bus.rd      = 1'b0;
        bus.clr_ovr = 1'b0;
        modelOvr    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkVal("reset count",   32'(bus.count),   32'd0);
        checkVal("reset empty",   32'(bus.empty),   32'd1);
        checkVal("reset rd_data", 32'(bus.rd_data), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].wr, vecs[i].data, vecs[i].rd, vecs[i].clr);
            checkVal($sformatf("vec%0d count", i),   32'(bus.count),       32'(vecs[i].expCount));
            checkVal($sformatf("vec%0d rd_data", i), 32'(bus.rd_data),     32'(vecs[i].expRdData));
            checkVal($sformatf("vec%0d overrun", i), 32'(bus.overrun),     32'(vecs[i].expOvr));
            checkVal($sformatf("vec%0d afull", i),   32'(bus.almost_full), 32'(vecs[i].expAf));
            checkVal($sformatf("vec%0d full", i),    32'(bus.full),        32'(vecs[i].expFull));
            checkVal($sformatf("vec%0d empty", i),   32'(bus.empty),       32'(vecs[i].expEmpty));
        end

        // Fill to full, overflow once, then drain in order.
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
            checkOutput("fill");
            checkVal("fill af_edge", 32'(bus.almost_full), 32'(i >= 12));
        end
        checkVal("fill full", 32'(bus.full), 32'd1);
        applyStimulus(1'b1, 8'h77, 1'b0, 1'b0);
        checkVal("ovr set",   32'(bus.overrun), 32'd1);
        checkVal("ovr count", 32'(bus.count),   32'd16);
        for (int i = 1; i <= 16; i++) begin
            checkVal("drain order", 32'(bus.rd_data), 32'(i));
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
            checkOutput("drain");
        end

        // Simultaneous write+read while full replaces the freed slot.
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkVal("clr ovr", 32'(bus.overrun), 32'd0);
        for (int i = 1; i <= 16; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h55, 1'b1, 1'b0);
        checkVal("full wr+rd ovr",   32'(bus.overrun), 32'd0);
        checkVal("full wr+rd count", 32'(bus.count),   32'd16);
        for (int k = 0; k < 15; k++) begin
            checkVal("full wr+rd order", 32'(bus.rd_data), 32'(k + 2));
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        end
        checkVal("full wr+rd last", 32'(bus.rd_data), 32'h55);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("after 55");

        // Pointers wrap past the last slot.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
            checkVal("wrap data", 32'(bus.rd_data), 32'(i));
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
            checkOutput("wrap");
        end

        // A new drop in the same cycle as clr_ovr keeps the flag set.
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'(i * 3), 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hEE, 1'b0, 1'b0);
        checkVal("ovr2 set", 32'(bus.overrun), 32'd1);
        applyStimulus(1'b1, 8'hEF, 1'b0, 1'b1);
        checkVal("ovr set wins", 32'(bus.overrun), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkVal("ovr cleared", 32'(bus.overrun), 32'd0);
        checkOutput("ovr2");

        // Asynchronous reset between edges with five bytes held.
        for (int i = 0; i < 16; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        checkVal("pre-reset count", 32'(bus.count), 32'd5);
        #2;
        reset = 1'b1;
        #1;
        checkVal("async count",   32'(bus.count),   32'd0);
        checkVal("async empty",   32'(bus.empty),   32'd1);
        checkVal("async rd_data", 32'(bus.rd_data), 32'h0);
        modelQ.delete();
        modelOvr = 1'b0;
        #1;
        reset = 1'b0;
        applyStimulus(1'b1, 8'h9E, 1'b0, 1'b0);
        checkVal("post-reset data", 32'(bus.rd_data), 32'h9E);
        checkOutput("post-reset");

        // Randomized traffic with alternating drain pressure.
        for (int c = 0; c < 3000; c++) begin
            rdProb = ((c / 250) % 2 == 1) ? 25 : 70;
            applyStimulus($urandom_range(0, 99) < 55,
                          8'($urandom),
                          $urandom_range(0, 99) < rdProb,
                          $urandom_range(0, 99) < 8);
            checkOutput("random");
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive buffer directly downstream of the UART receiver.
- Captures each byte presented with the receiver's one-cycle done tick into a circular FIFO.
- Presents the oldest byte first-word-fall-through to the bus-side reader.
- Reports occupancy, almost-full and a sticky overrun flag, so no received byte is silently lost.

Parameters:
DATA_W, 8, width of each stored byte (matches receiver dout)
ADDR_W, 4, address bits; depth = 2**ADDR_W = 16 entries
AF_LEVEL, 12, almost_full asserts when count >= AF_LEVEL; legal range 1..2**ADDR_W

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all control state immediately
wr_tick  input  1  one-cycle write strobe, driven by receiver rx_done_tick
wr_data  input  DATA_W  byte to store, valid when wr_tick=1
rd  input  1  pop strobe; consumes the byte currently on rd_data
rd_data  output  DATA_W  oldest stored byte (FWFT); 0 when empty
empty  output  1  FIFO holds no entries
full  output  1  FIFO holds 2**ADDR_W entries
almost_full  output  1  count >= AF_LEVEL
count  output  ADDR_W+1  current occupancy, 0..2**ADDR_W
overrun  output  1  sticky: a write was dropped because FIFO was full
clr_ovr  input  1  synchronous clear of overrun

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, named reset.
- Reset values:
  - wr_ptr=0, rd_ptr=0, count=0, overrun=0.
  - Hence empty=1, full=0, almost_full=0, rd_data=0.
  - Storage array is not reset.
  - Reset asserted mid-operation discards all contents immediately. No partial state survives.
- Storage: 2**ADDR_W x DATA_W register array, written at wr_ptr.
  - Pointers are ADDR_W bits and wrap modulo 2**ADDR_W (15 -> 0).
  - count is a separate ADDR_W+1-bit register.
- Write acceptance: write occurs when wr_tick=1 and (full=0 or rd=1 in the same cycle).
  - On write: mem[wr_ptr] <= wr_data, wr_ptr++.
- Read acceptance: read occurs when rd=1 and empty=0.
  - On read: rd_ptr++. rd while empty is ignored: no pointer change, no error flag.
- Count update: +1 on write-only, -1 on read-only, unchanged on simultaneous write+read.
- Simultaneous wr_tick and rd:
  - Not empty, not full: both occur, count unchanged.
  - Empty: write occurs, read ignored, count becomes 1. The new byte appears on rd_data the next cycle.
  - Full: both occur. The write lands in the slot freed by the read, no overrun, count stays 2**ADDR_W.
- Overrun:
  - wr_tick=1, full=1, rd=0: byte dropped, storage/pointers/count unchanged, overrun <= 1 at the next edge.
  - overrun stays 1 until clr_ovr=1 or reset.
  - If clr_ovr and a new overrun event occur in the same cycle, set wins (overrun=1).
- Latency:
  - A written byte is visible on rd_data and empty deasserts one cycle after the wr_tick edge.
  - rd_data updates to the next entry one cycle after a read edge.
  - rd_data is driven combinationally from mem[rd_ptr], gated to 0 when empty.
- Flags:
  - empty = (count==0), full = (count==2**ADDR_W), almost_full = (count>=AF_LEVEL).
  - All three are derived combinationally from the registered count, so they are glitch-free relative to clk.
- Consecutive wr_tick on back-to-back cycles must be accepted (the receiver never does this, but the FIFO must not rely on tick spacing).
- No X propagation: rd_data is forced 0 whenever empty, including after reset, when storage is uninitialised.

Test Plan:
- Reset then idle -> empty=1, full=0, count=0, overrun=0, rd_data=0x00. Then write 0xA5 -> next cycle empty=0, count=1, rd_data=0xA5.
- Write 0x01..0x10 (16 bytes), no reads:
  - almost_full rises on the cycle count reaches 12.
  - full=1 at count=16.
  - A 17th write of 0x77 -> overrun=1, count=16.
  - Reading 16 bytes returns 0x01..0x10 in order, no 0x77.
- Full FIFO, assert wr_tick=0x55 and rd together -> overrun stays 0, count stays 16, the 0x55 emerges last after 15 further reads.
- Empty FIFO, wr_tick=0x3C with rd=1 same cycle -> count=1, rd_data=0x3C next cycle. rd alone on empty -> count stays 0, pointers unchanged.
- Wrap-around: 20 rounds of write-one/read-one with values 0x00..0x13 -> every read returns the matching value and pointers wrap past 15. Force an overrun, then assert clr_ovr on the same cycle as another dropped write -> overrun remains 1; clr_ovr alone next cycle -> overrun=0.
- Reset mid-stream: with count=5, pulse reset asynchronously between edges -> count=0, empty=1, rd_data=0x00 immediately. A subsequent write of 0x9E reads back 0x9E.
